// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant,
// cycle-long bus locking and a stall watchdog that forces ERR.
module wb_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned TIMEOUT_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [7:0]            m0_dat_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,
    output logic [7:0]            m0_dat_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [7:0]            m1_dat_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,
    output logic [7:0]            m1_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [7:0]            s_dat_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    input  logic [7:0]            s_dat_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMIT =
        TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    state_t                   state_q, state_d;
    logic                     last_q;
    logic [TIMEOUT_WIDTH-1:0] wd_q;
    logic                     timeout_q;

    logic                  own_cyc, own_stb, own_we;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [7:0]            own_dat;
    logic                  s_term, fire, wd_clr;
    logic                  ack_g, err_g, rty_g;

    function automatic state_t arb(input logic c0, input logic c1,
                                   input logic last);
        if (c0 && c1) return last ? OWN0 : OWN1;
        if (c0)       return OWN0;
        if (c1)       return OWN1;
        return IDLE;
    endfunction

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        unique case (state_q)
            OWN0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_we  = m0_we_i;
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
            end
            OWN1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_we  = m1_we_i;
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
            end
            default: ;
        endcase
    end

    // Release re-arbitrates at once with the departing owner as `last`.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = arb(m0_cyc_i, m1_cyc_i, last_q);
            OWN0: if (!m0_cyc_i) state_d = arb(1'b0, m1_cyc_i, 1'b0);
            OWN1: if (!m1_cyc_i) state_d = arb(m0_cyc_i, 1'b0, 1'b1);
            default: state_d = IDLE;
        endcase
    end

    assign s_term = s_ack_i | s_err_i | s_rty_i;
    assign fire   = WD_EN && own_cyc && own_stb && !s_term &&
                    !timeout_q && (wd_q == WD_LIMIT);
    assign wd_clr = (state_d != state_q) || !own_cyc || !own_stb ||
                    s_term || fire || timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= fire;
            if (state_q == OWN0 && !m0_cyc_i) last_q <= 1'b0;
            if (state_q == OWN1 && !m1_cyc_i) last_q <= 1'b1;
            if (wd_clr)
                wd_q <= '0;
            else if (wd_q != '1)
                wd_q <= wd_q + TIMEOUT_WIDTH'(1);
        end
    end

    // The forced-error cycle hides the slave and drops its terminations.
    assign ack_g = s_ack_i & ~timeout_q;
    assign err_g = (s_err_i & ~timeout_q) | timeout_q;
    assign rty_g = s_rty_i & ~timeout_q;

    assign s_cyc_o = own_cyc & ~timeout_q;
    assign s_stb_o = own_stb & ~timeout_q;
    assign s_we_o  = own_we;
    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;

    assign m0_ack_o = (state_q == OWN0) & ack_g;
    assign m0_err_o = (state_q == OWN0) & err_g;
    assign m0_rty_o = (state_q == OWN0) & rty_g;
    assign m1_ack_o = (state_q == OWN1) & ack_g;
    assign m1_err_o = (state_q == OWN1) & err_g;
    assign m1_rty_o = (state_q == OWN1) & rty_g;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign grant_o   = {state_q == OWN1, state_q == OWN0};
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: arbitration, locking,
// alternation, watchdog and asynchronous reset.
module tb_wb_bus_arbiter;

    localparam int AW = 24;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [7:0]    m0_dat_i;
    logic          m0_ack_o, m0_err_o, m0_rty_o;
    logic [7:0]    m0_dat_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [7:0]    m1_dat_i;
    logic          m1_ack_o, m1_err_o, m1_rty_o;
    logic [7:0]    m1_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [7:0]    s_dat_o;
    logic          s_ack_i, s_err_i, s_rty_i;
    logic [7:0]    s_dat_i;
    logic [1:0]    grant_o;
    logic          timeout_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    wb_bus_arbiter #(
        .ADDR_WIDTH(AW),
        .TIMEOUT_WIDTH(8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic slave_ack(input logic [7:0] d);
        s_ack_i = 1'b1;
        s_dat_i = d;
        sb.push_back(d);
        #1;
    endtask

    task automatic check_read(input string tag, input int m);
        logic [7:0] exp;
        logic       a0, a1;
        a0 = (m == 0);
        a1 = (m == 1);
        chk({tag, "_ack0"}, 32'(m0_ack_o), 32'(a0));
        chk({tag, "_ack1"}, 32'(m1_ack_o), 32'(a1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'(1), 32'(0));
        end else begin
            exp = sb.pop_front();
            chk({tag, "_dat"}, 32'((m == 0) ? m0_dat_o : m1_dat_o),
                32'(exp));
        end
    endtask

    task automatic set_m(input int m, input logic v);
        if (m == 0) begin
            m0_cyc_i = v;
            m0_stb_i = v;
        end else begin
            m1_cyc_i = v;
            m1_stb_i = v;
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        m0_adr_i = 24'h000010; m0_dat_i = 8'h00;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        m1_adr_i = 24'h000020; m1_dat_i = 8'h00;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = 8'h00;

        tick();
        tick();
        chk("rst_grant", 32'(grant_o), 32'(0));
        chk("rst_timeout", 32'(timeout_o), 32'(0));
        chk("rst_scyc", 32'(s_cyc_o), 32'(0));
        chk("rst_term", 32'({m0_ack_o, m0_err_o, m0_rty_o,
                             m1_ack_o, m1_err_o, m1_rty_o}), 32'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Tie after reset goes to m0
        set_m(0, 1);
        set_m(1, 1);
        #1;
        chk("t1_idle_scyc", 32'(s_cyc_o), 32'(0));
        tick();
        chk("t1_grant", 32'(grant_o), 32'(1));
        chk("t1_adr", 32'(s_adr_o), 32'h10);
        chk("t1_scyc", 32'(s_cyc_o), 32'(1));
        slave_ack(8'h5A);
        check_read("t1_rd", 0);
        tick();
        s_ack_i = 0;
        set_m(0, 0);
        #1;
        chk("t1_gap_scyc", 32'(s_cyc_o), 32'(0));
        tick();
        chk("t1_handover", 32'(grant_o), 32'(2));
        chk("t1_adr1", 32'(s_adr_o), 32'h20);
        slave_ack(8'hC3);
        check_read("t1_rd1", 1);
        tick();
        s_ack_i = 0;
        set_m(1, 0);
        tick();
        chk("t1_idle", 32'(grant_o), 32'(0));

        // Lock across three strobed reads
        set_m(0, 1);
        set_m(1, 1);
        tick();
        chk("t2_grant", 32'(grant_o), 32'(1));
        for (int i = 0; i < 3; i++) begin
            slave_ack(8'hA0 + 8'(i));
            check_read("t2_rd", 0);
            tick();
            s_ack_i = 0;
            chk("t2_locked", 32'(grant_o), 32'(1));
        end
        set_m(0, 0);
        #1;
        chk("t2_gap_scyc", 32'(s_cyc_o), 32'(0));
        chk("t2_gap_grant", 32'(grant_o), 32'(1));
        tick();
        chk("t2_handover", 32'(grant_o), 32'(2));
        chk("t2_scyc", 32'(s_cyc_o), 32'(1));
        slave_ack(8'h77);
        check_read("t2_rd1", 1);
        tick();
        s_ack_i = 0;
        set_m(1, 0);
        tick();
        chk("t2_idle", 32'(grant_o), 32'(0));

        // Continuous requests alternate
        set_m(0, 1);
        set_m(1, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            int own;
            own = k % 2;
            chk("t3_alt", 32'(grant_o), 32'(own + 1));
            slave_ack(8'h10 + 8'(k));
            check_read("t3_rd", own);
            tick();
            s_ack_i = 0;
            set_m(own, 0);
            tick();
            set_m(own, 1);
        end
        set_m(0, 0);
        set_m(1, 0);
        tick();
        chk("t3_idle", 32'(grant_o), 32'(0));

        // Watchdog fires on stalled m1 write
        m1_we_i  = 1'b1;
        m1_dat_i = 8'h3C;
        set_m(1, 1);
        tick();
        chk("t4_grant", 32'(grant_o), 32'(2));
        chk("t4_we", 32'(s_we_o), 32'(1));
        chk("t4_dat", 32'(s_dat_o), 32'h3C);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_stall_err", 32'(m1_err_o), 32'(0));
            chk("t4_stall_to", 32'(timeout_o), 32'(0));
        end
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("t4_err", 32'(m1_err_o), 32'(1));
        chk("t4_timeout", 32'(timeout_o), 32'(1));
        chk("t4_scyc", 32'(s_cyc_o), 32'(0));
        chk("t4_sstb", 32'(s_stb_o), 32'(0));
        chk("t4_ack_drop", 32'(m1_ack_o), 32'(0));
        chk("t4_err0", 32'(m0_err_o), 32'(0));
        s_ack_i  = 1'b0;
        m1_stb_i = 1'b0;
        tick();
        chk("t4_err_pulse", 32'(m1_err_o), 32'(0));
        chk("t4_to_pulse", 32'(timeout_o), 32'(0));
        chk("t4_held", 32'(grant_o), 32'(2));
        m1_cyc_i = 1'b0;
        m1_we_i  = 1'b0;
        tick();
        chk("t4_idle", 32'(grant_o), 32'(0));

        // Ack on the firing cycle wins
        set_m(1, 1);
        tick();
        for (int i = 0; i < 4; i++) tick();
        slave_ack(8'h99);
        chk("t5_err", 32'(m1_err_o), 32'(0));
        check_read("t5_rd", 1);
        tick();
        s_ack_i = 0;
        chk("t5_to", 32'(timeout_o), 32'(0));
        chk("t5_err_after", 32'(m1_err_o), 32'(0));
        tick();
        chk("t5_to2", 32'(timeout_o), 32'(0));
        set_m(1, 0);
        tick();
        chk("t5_idle", 32'(grant_o), 32'(0));

        // Asynchronous reset mid-transfer
        set_m(1, 1);
        tick();
        chk("t6_grant", 32'(grant_o), 32'(2));
        set_m(0, 1);
        s_ack_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(grant_o), 32'(0));
        chk("t6_rst_scyc", 32'(s_cyc_o), 32'(0));
        chk("t6_rst_ack", 32'({m0_ack_o, m1_ack_o}), 32'(0));
        s_ack_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        chk("t6_tie_m0", 32'(grant_o), 32'(1));
        set_m(0, 0);
        set_m(1, 0);
        tick();
        tick();
        chk("t6_idle", 32'(grant_o), 32'(0));
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
